// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit for N source operands and a configurable pipeline depth.
// Optional saturating stall counter: define FWD_STALL_CNT_EN.
module fwd_hazard_unit #(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2,
    parameter int LOAD_STAGE = 2,
    parameter int REG_AW     = 5,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pipe_hold,
    input  logic                        flush_ex,
    input  logic                        id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src,
    input  logic [NUM_SRC-1:0]          id_src_used,
    input  logic [REG_AW-1:0]           id_dest,
    input  logic                        id_reg_write,
    input  logic                        id_is_load,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_src,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
    output logic                        stall_id,
    output logic [15:0]                 stall_cnt
);

    // Slot 0 is EX; slot k is k stages behind EX.
    logic [NUM_STAGES:0]  valid_r;
    logic [NUM_STAGES:0]  wr_r;
    logic [NUM_STAGES:0]  load_r;
    logic [REG_AW-1:0]    dest_r [0:NUM_STAGES];

    logic [NUM_SRC*SEL_W-1:0] fwd_sel_s;
    logic                     hazard_s;
    logic                     stall_id_s;

    function automatic logic slot_match(
        input logic              v,
        input logic              w,
        input logic [REG_AW-1:0] d,
        input logic [REG_AW-1:0] a
    );
        return v && w && (d != {REG_AW{1'b0}}) && (d == a);
    endfunction

    // Bypass select: scan oldest to youngest so the youngest eligible match is kept.
    always_comb begin
        fwd_sel_s = {(NUM_SRC*SEL_W){1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_STAGES; k >= 1; k--) begin
                if (slot_match(valid_r[k], wr_r[k], dest_r[k], ex_src[i*REG_AW +: REG_AW]) &&
                    !((k < LOAD_STAGE) && load_r[k])) begin
                    fwd_sel_s[i*SEL_W +: SEL_W] = SEL_W'(k);
                end else begin
                    fwd_sel_s[i*SEL_W +: SEL_W] = fwd_sel_s[i*SEL_W +: SEL_W];
                end
            end
        end
    end

    // Load-use detection: a load still too young to forward when ID reaches EX.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = 0; j < LOAD_STAGE - 1; j++) begin
                if (id_src_used[i] && load_r[j] &&
                    slot_match(valid_r[j], wr_r[j], dest_r[j], id_src[i*REG_AW +: REG_AW])) begin
                    hazard_s = 1'b1;
                end else begin
                    hazard_s = hazard_s;
                end
            end
        end
        stall_id_s = id_valid && !pipe_hold && hazard_s;
    end

    // Record pipeline: shift toward older slots, bubble into EX on stall, flush or empty ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {(NUM_STAGES+1){1'b0}};
            wr_r    <= {(NUM_STAGES+1){1'b0}};
            load_r  <= {(NUM_STAGES+1){1'b0}};
            for (int k = 0; k <= NUM_STAGES; k++) begin
                dest_r[k] <= {REG_AW{1'b0}};
            end
        end else if (!pipe_hold) begin
            for (int k = 1; k <= NUM_STAGES; k++) begin
                valid_r[k] <= valid_r[k-1];
                wr_r[k]    <= wr_r[k-1];
                load_r[k]  <= load_r[k-1];
                dest_r[k]  <= dest_r[k-1];
            end
            if (stall_id_s || flush_ex || !id_valid) begin
                valid_r[0] <= 1'b0;
                wr_r[0]    <= 1'b0;
                load_r[0]  <= 1'b0;
                dest_r[0]  <= {REG_AW{1'b0}};
            end else begin
                valid_r[0] <= 1'b1;
                wr_r[0]    <= id_reg_write;
                load_r[0]  <= id_is_load;
                dest_r[0]  <= id_dest;
            end
        end
    end

    assign fwd_sel  = fwd_sel_s;
    assign stall_id = stall_id_s;

`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating stall-cycle counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'h0000;
        end else if (stall_id_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench: default unit plus a LOAD_STAGE=3/NUM_STAGES=3 unit, both checked against a queue-based model.
module tb_fwd_hazard_unit;

    localparam int NSRC = 2;
    localparam int AW   = 5;
    localparam int NS_A = 2;
    localparam int LS_A = 2;
    localparam int NS_B = 3;
    localparam int LS_B = 3;
    localparam int SW_A = $clog2(NS_A + 1);
    localparam int SW_B = $clog2(NS_B + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pipe_hold = 1'b0;
    logic flush_ex = 1'b0;
    logic id_valid = 1'b0;
    logic id_reg_write = 1'b0;
    logic id_is_load = 1'b0;
    logic [NSRC*AW-1:0] id_src = '0;
    logic [NSRC*AW-1:0] ex_src = '0;
    logic [NSRC-1:0]    id_src_used = '0;
    logic [AW-1:0]      id_dest = '0;
    logic [NSRC*SW_A-1:0] fwd_a;
    logic [NSRC*SW_B-1:0] fwd_b;
    logic stall_a, stall_b;
    logic [15:0] cnt_a, cnt_b;

    int test_cnt = 0;
    int fail_cnt = 0;

    typedef struct packed {
        bit         v;
        bit         w;
        logic [4:0] d;
        bit         l;
    } rec_t;

    // In-flight instructions, index 0 = the one in EX, index k = k stages older.
    rec_t qa[$];
    rec_t qb[$];
    int   exp_cnt_a = 0;
    int   exp_cnt_b = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.NUM_SRC(NSRC), .NUM_STAGES(NS_A), .LOAD_STAGE(LS_A), .REG_AW(AW)) dut_a (
        .clk(clk), .rst_n(rst_n), .pipe_hold(pipe_hold), .flush_ex(flush_ex),
        .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ex_src(ex_src),
        .fwd_sel(fwd_a), .stall_id(stall_a), .stall_cnt(cnt_a)
    );

    fwd_hazard_unit #(.NUM_SRC(NSRC), .NUM_STAGES(NS_B), .LOAD_STAGE(LS_B), .REG_AW(AW)) dut_b (
        .clk(clk), .rst_n(rst_n), .pipe_hold(pipe_hold), .flush_ex(flush_ex),
        .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ex_src(ex_src),
        .fwd_sel(fwd_b), .stall_id(stall_b), .stall_cnt(cnt_b)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input rec_t r, input logic [4:0] a);
        return r.v && r.w && (r.d != 5'd0) && (r.d == a);
    endfunction

    function automatic int ref_fwd(input int which, input logic [4:0] a);
        rec_t q[$];
        int ns, ls;
        if (which == 0) begin q = qa; ns = NS_A; ls = LS_A; end
        else            begin q = qb; ns = NS_B; ls = LS_B; end
        for (int k = 1; k <= ns && k < q.size(); k++)
            if (hit(q[k], a) && !(k < ls && q[k].l)) return k;
        return 0;
    endfunction

    function automatic bit ref_stall(input int which);
        rec_t q[$];
        int ls;
        if (which == 0) begin q = qa; ls = LS_A; end
        else            begin q = qb; ls = LS_B; end
        if (!id_valid || pipe_hold) return 1'b0;
        for (int i = 0; i < NSRC; i++)
            for (int j = 0; j <= ls - 2 && j < q.size(); j++)
                if (id_src_used[i] && q[j].l && hit(q[j], id_src[i*AW +: AW])) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_all();
        for (int i = 0; i < NSRC; i++) begin
            check_val($sformatf("fwdA[%0d]", i), 32'(fwd_a[i*SW_A +: SW_A]), ref_fwd(0, ex_src[i*AW +: AW]));
            check_val($sformatf("fwdB[%0d]", i), 32'(fwd_b[i*SW_B +: SW_B]), ref_fwd(1, ex_src[i*AW +: AW]));
        end
        check_val("stallA", 32'(stall_a), 32'(ref_stall(0)));
        check_val("stallB", 32'(stall_b), 32'(ref_stall(1)));
`ifdef FWD_STALL_CNT_EN
        check_val("cntA", 32'(cnt_a), exp_cnt_a);
        check_val("cntB", 32'(cnt_b), exp_cnt_b);
`else
        check_val("cntA", 32'(cnt_a), 32'd0);
        check_val("cntB", 32'(cnt_b), 32'd0);
`endif
    endtask

    task automatic apply(input bit v, input logic [4:0] dst, input bit wr, input bit ld,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                         input logic [4:0] e0, input logic [4:0] e1, input bit hold, input bit fl);
        @(negedge clk);
        id_valid = v; id_dest = dst; id_reg_write = wr; id_is_load = ld;
        id_src = {s1, s0}; id_src_used = used; ex_src = {e1, e0};
        pipe_hold = hold; flush_ex = fl;
        #1;
        check_all();
    endtask

    task automatic tick();
        bit sa, sb;
        rec_t ra, rb;
        sa = ref_stall(0);
        sb = ref_stall(1);
        @(posedge clk);
        if (!pipe_hold) begin
            ra = '{v: id_valid && !sa && !flush_ex, w: id_reg_write, d: id_dest, l: id_is_load};
            rb = '{v: id_valid && !sb && !flush_ex, w: id_reg_write, d: id_dest, l: id_is_load};
            qa.push_front(ra);
            qb.push_front(rb);
            if (qa.size() > NS_A + 1) void'(qa.pop_back());
            if (qb.size() > NS_B + 1) void'(qb.pop_back());
        end
        if (sa && exp_cnt_a < 65535) exp_cnt_a++;
        if (sb && exp_cnt_b < 65535) exp_cnt_b++;
    endtask

    task automatic drain();
        for (int n = 0; n < 4; n++) begin
            apply(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
            tick();
        end
    endtask

    initial begin
        #2;
        check_all();
        check_val("rst_stallA", 32'(stall_a), 32'd0);
        check_val("rst_fwdA", 32'(fwd_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // add $3 then sub reading $3: forwarded from stage 1
        apply(1, 5'd3, 1, 0, 5'd1, 5'd2, 2'b11, 5'd0, 5'd0, 0, 0); tick();
        apply(1, 5'd4, 1, 0, 5'd3, 5'd2, 2'b11, 5'd1, 5'd2, 0, 0);
        check_val("t1_nostall", 32'(stall_a), 32'd0);
        tick();
        apply(0, 5'd0, 0, 0, 5'd0, 5'd0, 2'b00, 5'd3, 5'd2, 0, 0);
        check_val("t1_fwd1", 32'(fwd_a[0 +: SW_A]), 32'd1);
        tick();

        // producer, unrelated, consumer on operand 1: stage 2
        drain();
        apply(1, 5'd3, 1, 0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0, 0); tick();
        apply(1, 5'd7, 1, 0, 5'd1, 5'd1, 2'b11, 5'd0, 5'd0, 0, 0); tick();
        apply(1, 5'd8, 1, 0, 5'd1, 5'd3, 2'b11, 5'd1, 5'd1, 0, 0); tick();
        apply(0, 5'd0, 0, 0, 5'd0, 5'd0, 2'b00, 5'd1, 5'd3, 0, 0);
        check_val("t2_fwd2", 32'(fwd_a[SW_A +: SW_A]), 32'd2);
        tick();

        // two producers of $3: youngest wins
        drain();
        apply(1, 5'd3, 1, 0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0, 0); tick();
        apply(1, 5'd3, 1, 0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0, 0); tick();
        apply(0, 5'd0, 0, 0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0, 0); tick();
        apply(0, 5'd0, 0, 0, 5'd0, 5'd0, 2'b00, 5'd3, 5'd0, 0, 0);
        check_val("t3_youngest", 32'(fwd_a[0 +: SW_A]), 32'd1);
        tick();

        // writes to $0 never forward
        drain();
        apply(1, 5'd0, 1, 0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0, 0); tick();
        apply(0, 5'd0, 0, 0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0, 0);
        check_val("t4_r0", 32'(fwd_a[0 +: SW_A]), 32'd0);
        tick();

        // lw $5 then consumer: A stalls 1 cycle, B stalls 2
        drain();
        apply(1, 5'd5, 1, 1, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0, 0); tick();
        apply(1, 5'd9, 1, 0, 5'd5, 5'd1, 2'b01, 5'd0, 5'd0, 0, 0);
        check_val("t5_stallA_c1", 32'(stall_a), 32'd1);
        check_val("t5_stallB_c1", 32'(stall_b), 32'd1);
        tick();
        apply(1, 5'd9, 1, 0, 5'd5, 5'd1, 2'b01, 5'd0, 5'd0, 0, 0);
        check_val("t5_stallA_c2", 32'(stall_a), 32'd0);
        check_val("t5_stallB_c2", 32'(stall_b), 32'd1);
        tick();
        apply(1, 5'd9, 1, 0, 5'd5, 5'd1, 2'b01, 5'd5, 5'd1, 0, 0);
        check_val("t5_fwdA2", 32'(fwd_a[0 +: SW_A]), 32'd2);
        check_val("t5_stallB_c3", 32'(stall_b), 32'd0);
        tick();
        apply(0, 5'd0, 0, 0, 5'd0, 5'd0, 2'b00, 5'd5, 5'd1, 0, 0);
        check_val("t5_fwdB3", 32'(fwd_b[0 +: SW_B]), 32'd3);
        tick();

        // load match on an unused operand does not stall
        drain();
        apply(1, 5'd5, 1, 1, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0, 0); tick();
        apply(1, 5'd9, 1, 0, 5'd1, 5'd5, 2'b01, 5'd0, 5'd0, 0, 0);
        check_val("t6_unusedA", 32'(stall_a), 32'd0);
        check_val("t6_unusedB", 32'(stall_b), 32'd0);
        tick();

        // pipe_hold mid-stall freezes records, stall resumes after release
        drain();
        apply(1, 5'd6, 1, 1, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0, 0); tick();
        apply(1, 5'd9, 1, 0, 5'd6, 5'd1, 2'b01, 5'd0, 5'd0, 0, 0); tick();
        apply(1, 5'd9, 1, 0, 5'd6, 5'd1, 2'b01, 5'd0, 5'd0, 1, 0);
        check_val("t7_holdB", 32'(stall_b), 32'd0);
        tick();
        apply(1, 5'd9, 1, 0, 5'd6, 5'd1, 2'b01, 5'd0, 5'd0, 0, 0);
        check_val("t7_resumeB", 32'(stall_b), 32'd1);
        tick();
        apply(1, 5'd9, 1, 0, 5'd6, 5'd1, 2'b01, 5'd0, 5'd0, 0, 0);
        check_val("t7_doneB", 32'(stall_b), 32'd0);
        tick();

        // reset mid-stall clears everything at once
        drain();
        apply(1, 5'd5, 1, 1, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0, 0); tick();
        apply(1, 5'd3, 1, 1, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 0, 0); tick();
        apply(1, 5'd9, 1, 0, 5'd5, 5'd3, 2'b11, 5'd5, 5'd0, 0, 0);
        check_val("t8_pre_stallB", 32'(stall_b), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        qa.delete(); qb.delete();
        exp_cnt_a = 0; exp_cnt_b = 0;
        check_val("t8_stallA", 32'(stall_a), 32'd0);
        check_val("t8_stallB", 32'(stall_b), 32'd0);
        check_val("t8_fwdA", 32'(fwd_a), 32'd0);
        check_val("t8_fwdB", 32'(fwd_b), 32'd0);
        check_val("t8_cntA", 32'(cnt_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic on a small register set to provoke matches
        for (int n = 0; n < 2000; n++) begin
            apply(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 1'($urandom),
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  2'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
